obstacle_feed: RTL and testbench

- Game-control stage that feeds the 8:1 lane mux and consumes its output.
- Holds the current 8-lane obstacle row and the player lane, and drives them onto the mux as in[7:0], sel[2:0] and e.
- Takes the mux output back in as the collision flag `hit`.
- Scrolls a new row on each game tick. Rows come from an internal LFSR, and every row is guaranteed to contain a hole.
- Runs an IDLE/RUN/OVER state machine and keeps a saturating score.

---
 rtl/obstacle_pkg.sv | 21 ++
 rtl/obstacle_lfsr.sv | 29 ++
 rtl/obstacle_feed.sv | 115 +++++++++++
 tb/tb_obstacle_feed.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle game control stage.
// Holds the FSM state encoding, lane geometry and the LFSR step function.
package obstacle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int LANES  = 8;
    localparam int LANE_W = 3;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Fibonacci step: shift left, feed back parity of taps 7,5,4,3.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 8-bit Fibonacci LFSR used as the obstacle row source.
// Ports: clk, rst_n (sync, active-low), load (reload SEED), advance,
//        value (current state), next (state after one advance).
module obstacle_lfsr
    import obstacle_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hB8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] value,
    output logic [7:0] next
);

    assign next = lfsr_step(value);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (advance) begin
            value <= next;
        end
    end

endmodule

// File: rtl/obstacle_feed.sv
// Game-control stage: drives row/lane/enable onto the 8:1 lane mux and
// reads back the mux output as the collision flag.
// Ports: clk, rst_n (sync, active-low), start, tick, left, right, hit (in);
//        row, lane_sel, mux_en, game_over, score (registered outputs).
module obstacle_feed
    import obstacle_pkg::*;
#(
    parameter logic [7:0] SEED       = 8'hB8,
    parameter int         GAP_ROWS   = 2,
    parameter int         START_LANE = 3,
    parameter int         SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               tick,
    input  logic               left,
    input  logic               right,
    input  logic               hit,
    output logic [7:0]         row,
    output logic [LANE_W-1:0]  lane_sel,
    output logic               mux_en,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    localparam logic [3:0]        GAP_INIT  = 4'(GAP_ROWS);
    localparam logic [LANE_W-1:0] LANE_INIT = LANE_W'(START_LANE);
    localparam logic [LANE_W-1:0] LANE_MAX  = LANE_W'(LANES - 1);

    state_t               state, state_n;
    logic [7:0]           row_n;
    logic [LANE_W-1:0]    lane_n;
    logic [SCORE_W-1:0]   score_n;
    logic [3:0]           gap_cnt, gap_n;
    logic                 advance;
    logic [7:0]           lfsr_val;
    logic [7:0]           lfsr_nxt;

    obstacle_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (1'b0),
        .advance (advance),
        .value   (lfsr_val),
        .next    (lfsr_nxt)
    );

    always_comb begin
        state_n = state;
        row_n   = row;
        lane_n  = lane_sel;
        score_n = score;
        gap_n   = gap_cnt;
        advance = 1'b0;
        unique case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_n = RUN;
                    row_n   = '0;
                    score_n = '0;
                    lane_n  = LANE_INIT;
                    gap_n   = GAP_INIT;
                end
            end
            RUN: begin
                // A collision freezes the frame so it can be displayed.
                if (hit) begin
                    state_n = OVER;
                end else begin
                    if (left && !right && lane_sel != '0)
                        lane_n = lane_sel - 1'b1;
                    else if (right && !left && lane_sel != LANE_MAX)
                        lane_n = lane_sel + 1'b1;
                    if (tick) begin
                        if (score != '1)
                            score_n = score + SCORE_W'(1);
                        if (gap_cnt != '0) begin
                            row_n = '0;
                            gap_n = gap_cnt - 1'b1;
                        end else begin
                            advance = 1'b1;
                            // Clear the lane indexed by the low bits so
                            // every obstacle row has at least one hole.
                            row_n = lfsr_nxt & ~(8'd1 << lfsr_nxt[2:0]);
                            gap_n = GAP_INIT;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            lane_sel  <= LANE_INIT;
            score     <= '0;
            gap_cnt   <= GAP_INIT;
            mux_en    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            lane_sel  <= lane_n;
            score     <= score_n;
            gap_cnt   <= gap_n;
            mux_en    <= (state_n == RUN);
            game_over <= (state_n == OVER);
        end
    end

endmodule

// File: tb/tb_obstacle_feed.sv
// Testbench for obstacle_feed with an external 8:1 mux model.
// Compares the DUT against a behavioural game model every cycle.
module tb_obstacle_feed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, tick, left, right, hit;
    logic [7:0] row;
    logic [2:0] lane_sel;
    logic       mux_en, game_over;
    logic [7:0] score;

    logic       start2, tick2, left2, right2, hit2;
    logic [7:0] row2;
    logic [2:0] lane2;
    logic       en2, over2;
    logic [1:0] score2;

    // The lane mux sitting between the two game ports.
    assign hit  = row[lane_sel] & mux_en;
    assign hit2 = row2[lane2] & en2;

    obstacle_feed #(
        .SEED(8'hB8), .GAP_ROWS(2), .START_LANE(3), .SCORE_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
        .left(left), .right(right), .hit(hit), .row(row),
        .lane_sel(lane_sel), .mux_en(mux_en),
        .game_over(game_over), .score(score)
    );

    obstacle_feed #(
        .SEED(8'hB8), .GAP_ROWS(2), .START_LANE(3), .SCORE_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .tick(tick2),
        .left(left2), .right(right2), .hit(hit2), .row(row2),
        .lane_sel(lane2), .mux_en(en2),
        .game_over(over2), .score(score2)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase 0 idle, 1 playing, 2 game over.
    int m_ph, m_row, m_lane, m_score, m_gap, m_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int parity_taps(input int v);
        int p = 0;
        if (v & 128) p++;
        if (v & 32)  p++;
        if (v & 16)  p++;
        if (v & 8)   p++;
        return p % 2;
    endfunction

    task automatic new_game();
        m_ph    = 1;
        m_row   = 0;
        m_score = 0;
        m_lane  = 3;
        m_gap   = 2;
    endtask

    task automatic model_edge();
        int nxt;
        bit crash;
        if (!rst_n) begin
            m_ph = 0; m_row = 0; m_lane = 3;
            m_score = 0; m_gap = 2; m_lfsr = 'hB8;
        end else if (m_ph != 1) begin
            if (start) new_game();
        end else begin
            crash = ((m_row >> m_lane) % 2) == 1;
            if (crash) begin
                m_ph = 2;
            end else begin
                if (left && !right && m_lane > 0) m_lane--;
                if (right && !left && m_lane < 7) m_lane++;
                if (tick) begin
                    if (m_score < 255) m_score++;
                    if (m_gap > 0) begin
                        m_row = 0;
                        m_gap--;
                    end else begin
                        nxt    = ((m_lfsr * 2) % 256) + parity_taps(m_lfsr);
                        m_lfsr = nxt;
                        m_row  = nxt - (nxt & (1 << (nxt % 8)));
                        m_gap  = 2;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("row", row, m_row);
        chk("lane", lane_sel, m_lane);
        chk("mux_en", mux_en, (m_ph == 1));
        chk("game_over", game_over, (m_ph == 2));
        chk("score", score, m_score);
    endtask

    task automatic pulse_tick();
        tick = 1'b1; step(); tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tick = 1'b0;
        left = 1'b0; right = 1'b0;
        start2 = 1'b0; tick2 = 1'b0; left2 = 1'b0; right2 = 1'b0;

        step(); step();
        chk("rst_row", row, 0);
        chk("rst_lane", lane_sel, 3);
        chk("rst_en", mux_en, 0);
        chk("rst_over", game_over, 0);
        chk("rst_score", score, 0);
        rst_n = 1'b1;

        start = 1'b1; step(); start = 1'b0;
        chk("start_en", mux_en, 1);
        for (int i = 0; i < 5; i++) begin
            left = 1'b1; step(); left = 1'b0;
        end
        chk("lane_sat0", lane_sel, 0);
        for (int i = 0; i < 9; i++) begin
            right = 1'b1; step(); right = 1'b0;
        end
        chk("lane_sat7", lane_sel, 7);
        left = 1'b1; right = 1'b1; step(); left = 1'b0; right = 1'b0;
        chk("lane_both", lane_sel, 7);

        rst_n = 1'b0; step(); rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        pulse_tick(); pulse_tick(); pulse_tick();
        chk("row3", row, 'h70);
        chk("score3", score, 3);
        right = 1'b1; step(); right = 1'b0;
        chk("lane4", lane_sel, 4);
        chk("hit", hit, 1);
        pulse_tick();
        chk("over", game_over, 1);
        chk("over_en", mux_en, 0);
        chk("over_score", score, 3);
        chk("over_row", row, 'h70);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_score", score, 0);
        chk("restart_lane", lane_sel, 3);
        pulse_tick(); pulse_tick(); pulse_tick();
        chk("row_cont", row, 'hE0);
        pulse_tick(); pulse_tick();
        chk("score5", score, 5);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midrst_score", score, 0);
        chk("midrst_en", mux_en, 0);

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 15) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            left  = ($urandom_range(0, 3) == 0);
            right = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; start = 1'b0; tick = 1'b0;
        left = 1'b0; right = 1'b0;

        rst_n = 1'b0; step(); rst_n = 1'b1;
        start2 = 1'b1; step(); start2 = 1'b0;
        chk("s2_en", en2, 1);
        for (int i = 1; i <= 5; i++) begin
            tick2 = 1'b1; step(); tick2 = 1'b0;
            chk("s2_score", score2, (i < 3) ? i : 3);
        end
        chk("s2_alive", over2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
